// File: rtl/limb_add_stream.sv
// Streaming multi-limb adder: least-significant limb first, carry chained in a register.
// Optional build macro LIMB_ADD_SUB_EN adds an in_sub port for packet-wide subtraction.
module limb_add_stream #(
  parameter int W         = 32,
  parameter int MAX_LIMBS = 16,
  parameter int CW        = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_first,
  input  logic         in_last,
`ifdef LIMB_ADD_SUB_EN
  input  logic         in_sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_s,
  output logic         out_last,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Limb add: {carry, sum} of two W-bit limbs plus carry-in.
  function automatic logic [W:0] add_limb(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Two's-complement overflow of the final limb, judged from the sign bits.
  function automatic logic ovf_flag(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                    input logic signed [W-1:0] s);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  state_t        state;
  logic          carry;
  logic [CW-1:0] cnt;
`ifdef LIMB_ADD_SUB_EN
  logic          sub_lat;
`endif

  logic          vld_p1;
  logic [W-1:0]  s_p1;
  logic          last_p1;
  logic          cout_p1;
  logic          ovf_p1;
  logic          err_p1;

  logic          accept;
  logic          emit;
  logic          drop;
  logic          proto_err;
  logic          forced;
  logic          last_eff;
  logic          sub_beat;
  logic          cin;
  logic [W-1:0]  b_eff;
  logic [W:0]    sum;
  logic [CW-1:0] cnt_nxt;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    emit      = 1'b0;
    drop      = 1'b0;
    proto_err = 1'b0;
    cin       = 1'b0;
    cnt_nxt   = cnt;
`ifdef LIMB_ADD_SUB_EN
    sub_beat  = in_first ? in_sub : sub_lat;
`else
    sub_beat  = 1'b0;
`endif
    if (in_first) begin
      // A first beat always starts a packet; inside an open packet it also flags the abandonment.
      emit      = 1'b1;
      cin       = sub_beat;
      cnt_nxt   = CW'(1);
      proto_err = (state == ACTIVE);
    end else if (state == ACTIVE) begin
      emit    = 1'b1;
      cin     = carry;
      cnt_nxt = cnt + CW'(1);
    end else begin
      drop = 1'b1;
    end
    b_eff    = sub_beat ? ~in_b : in_b;
    sum      = add_limb(in_a, b_eff, cin);
    forced   = emit && !in_last && (cnt_nxt == CW'(MAX_LIMBS));
    last_eff = in_last || forced;
  end

  // Stage p0 -> p1: accepted beat lands in the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      carry   <= 1'b0;
      cnt     <= '0;
`ifdef LIMB_ADD_SUB_EN
      sub_lat <= 1'b0;
`endif
      vld_p1  <= 1'b0;
      s_p1    <= '0;
      last_p1 <= 1'b0;
      cout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      err_p1 <= accept && (drop || proto_err || forced);
      if (accept && emit) begin
        state   <= last_eff ? IDLE : ACTIVE;
        carry   <= sum[W];
        cnt     <= cnt_nxt;
`ifdef LIMB_ADD_SUB_EN
        sub_lat <= sub_beat;
`endif
        vld_p1  <= 1'b1;
        s_p1    <= sum[W-1:0];
        last_p1 <= last_eff;
        cout_p1 <= last_eff && sum[W];
        ovf_p1  <= last_eff && ovf_flag(in_a, b_eff, sum[W-1:0]);
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_s     = s_p1;
  assign out_last  = last_p1;
  assign out_cout  = cout_p1;
  assign out_ovf   = ovf_p1;
  assign err       = err_p1;

endmodule

// File: tb/tb_limb_add_stream.sv
// Directed bench for limb_add_stream (MAX_LIMBS=4); subtract steps need LIMB_ADD_SUB_EN.
module tb_limb_add_stream;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_first;
  logic         in_last;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_s;
  logic         out_last;
  logic         out_cout;
  logic         out_ovf;
  logic         err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  limb_add_stream #(.W(W), .MAX_LIMBS(4), .CW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_first (in_first),
    .in_last  (in_last),
`ifdef LIMB_ADD_SUB_EN
    .in_sub   (in_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s    (out_s),
    .out_last (out_last),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic first, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_first = first;
    in_last  = last;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] s, input logic last,
                         input logic cout, input logic ovf);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".s"}, out_s, s);
    chk({tag, ".last"}, out_last, last);
    chk({tag, ".cout"}, out_cout, cout);
    chk({tag, ".ovf"}, out_ovf, ovf);
  endtask

  logic [W-1:0] exp_f [4];
  logic [W-1:0] held_s;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.s", out_s, 32'h0);
    chk("rst.last", out_last, 1'b0);
    chk("rst.cout", out_cout, 1'b0);
    chk("rst.ovf", out_ovf, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst.in_ready", in_ready, 1'b1);
    rst = 1'b0;
    tick();

    // Single limb wraps to zero with carry out
    beat(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_out("single", 32'h0, 1'b1, 1'b1, 1'b0);
    chk("single.err", err, 1'b0);
    tick();
    chk("single.drain", out_valid, 1'b0);

    // Two-limb chain: carry from limb 0 pushes limb 1 into signed overflow
    beat(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
    tick();
    chk_out("chain0", 32'h0, 1'b0, 1'b0, 1'b0);
    beat(32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_out("chain1", 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    tick();

    // Backpressure: first limb held, second limb must wait and use its carry
    out_ready = 1'b0;
    beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    beat(32'h1, 32'h2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp.in_ready", in_ready, 1'b0);
      chk_out("bp.hold", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_out("bp.limb1", 32'h4, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp.drain", out_valid, 1'b0);

    // Non-first beat while idle is dropped
    beat(32'h1, 32'h1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("idle_drop.err", err, 1'b1);
    chk("idle_drop.valid", out_valid, 1'b0);
    tick();
    chk("idle_drop.err_clear", err, 1'b0);

    // First beat inside an open packet restarts with cin=0
    beat(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
    tick();
    chk("restart.err0", err, 1'b0);
    beat(32'h5, 32'h6, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("restart.err", err, 1'b1);
    chk_out("restart", 32'hB, 1'b1, 1'b0, 1'b0);
    tick();

    // Forced termination after 4 limbs; limb 0 carries, then each limb adds 0+0+1
    exp_f[0] = 32'h0; exp_f[1] = 32'h1; exp_f[2] = 32'h1; exp_f[3] = 32'h1;
    for (int i = 0; i < 4; i++) begin
      beat(32'h8000_0000, 32'h8000_0000, (i == 0), 1'b0);
      tick();
      chk_out("forced", exp_f[i], (i == 3), (i == 3), (i == 3));
      chk("forced.err", err, (i == 3));
    end
    beat(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("forced.drop_err", err, 1'b1);
    chk("forced.drop_valid", out_valid, 1'b0);
    tick();

    // Reset mid-packet discards the held beat and the open packet
    out_ready = 1'b0;
    beat(32'h1, 32'h1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    held_s = out_s;
    chk("midrst.pre", held_s, 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("midrst.valid", out_valid, 1'b0);
    chk("midrst.s", out_s, 32'h0);
    chk("midrst.last", out_last, 1'b0);
    chk("midrst.err", err, 1'b0);
    beat(32'h3, 32'h3, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("midrst.drop_err", err, 1'b1);
    chk("midrst.drop_valid", out_valid, 1'b0);
    tick();

`ifdef LIMB_ADD_SUB_EN
    // 5 - 7 borrows: result -2, cout=0
    in_sub = 1'b1;
    beat(32'h5, 32'h7, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_out("sub1", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    tick();
    // Two-limb subtract with in_sub dropped on limb 1: 0x1_00000000 - 1 = 0x0_FFFFFFFF, no borrow
    beat(32'h0, 32'h1, 1'b1, 1'b0);
    tick();
    in_sub = 1'b0;
    chk_out("sub2.0", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    beat(32'h1, 32'h0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_out("sub2.1", 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
